ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the EX stage of the 5-stage RISC-V core. Generates PC/IF-ID write enables, IF-ID/ID-EX flushes and an EX hold. Sources are load-use hazards, taken branch/jump redirects resolved in EX, and multi-cycle ALU operations (MUL/DIV class) that occupy EX for a fixed latency. Forwarding stays in EX; this block handles only cases forwarding cannot cover.

Parameters:
MC_LAT, 4, total cycles a multi-cycle op occupies EX (legal range 2..16)
CNT_W, 4, width of the multi-cycle down-counter (must hold MC_LAT-2)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
MemRead_ex  input  1  instruction in EX is a load
RegWrite_ex  input  1  instruction in EX writes rd
rdAddr_ex  input  5  destination register of EX instruction
rs1Addr_id  input  5  rs1 of ID instruction
rs2Addr_id  input  5  rs2 of ID instruction
rs1Used_id  input  1  ID instruction reads rs1
rs2Used_id  input  1  ID instruction reads rs2
BranchTaken_ex  input  1  EX resolved taken branch/JAL/JALR
MultiCycle_ex  input  1  EX holds a multi-cycle ALU op
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IFIDFlush  output  1  clear IF/ID to NOP
IDEXFlush  output  1  insert bubble into ID/EX
EXHold  output  1  freeze ID/EX; EX/MEM captures bubble
mc_busy  output  1  FSM in MC_BUSY
mc_done  output  1  one-cycle pulse on final EX cycle of multi-cycle op

Behaviour:
- States: IDLE, MC_BUSY. Counter cnt[CNT_W-1:0].
- Reset (async, rst_n=0): state=IDLE, cnt=0; outputs PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0, EXHold=0, mc_busy=0, mc_done=0. Reset mid-op abandons the op immediately.
- Outputs are combinational from state, cnt and inputs. Only state and cnt are registered.
- Default (no event): PCWrite=1, IFIDWrite=1, all flush/hold=0.
- Priority in IDLE: redirect > multi-cycle > load-use.
- Redirect (IDLE, BranchTaken_ex=1): PCWrite=1, IFIDFlush=1, IDEXFlush=1. Single cycle; state unchanged.
- Multi-cycle entry (IDLE, MultiCycle_ex=1, no redirect): EXHold=1, PCWrite=0, IFIDWrite=0. Next state MC_BUSY, cnt<=MC_LAT-2.
- MC_BUSY, cnt!=0: EXHold=1, PCWrite=0, IFIDWrite=0, mc_busy=1, cnt<=cnt-1. All other inputs ignored.
- MC_BUSY, cnt==0: final cycle. EXHold=0, PCWrite=1, IFIDWrite=1, mc_busy=1, mc_done=1. Next state IDLE.
- Net effect: EXHold is asserted for exactly MC_LAT-1 consecutive cycles per op.
- Back-to-back multi-cycle ops: the second is detected in the IDLE cycle after mc_done, and the sequence restarts.
- Load-use (IDLE, no redirect, no multi-cycle):
  - Condition: MemRead_ex & RegWrite_ex & rdAddr_ex!=0 & ((rs1Used_id & rdAddr_ex==rs1Addr_id) | (rs2Used_id & rdAddr_ex==rs2Addr_id)).
  - Response: PCWrite=0, IFIDWrite=0, IDEXFlush=1, for one cycle.
- rdAddr_ex==0 never causes a stall. An unused source operand never causes a stall.
- A load in EX plus BranchTaken_ex is impossible by construction; redirect wins regardless.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs ldu_stall_cnt[31:0], mc_stall_cnt[31:0] and flush_cnt[31:0]. Each is a saturating counter at 32'hFFFF_FFFF.
- Counting rules:
  - ldu_stall_cnt increments on each load-use stall cycle.
  - mc_stall_cnt increments on each EXHold=1 cycle.
  - flush_cnt increments on each redirect cycle.
- All three reset to 0 asynchronously.
- Undefined: counters and ports are absent. Core behaviour is identical.

Decomposition:
- Shared package ex_hazard_pkg holds: state encoding (IDLE=1'b0, MC_BUSY=1'b1), default MC_LAT, and the REG_ZERO=5'd0 constant.
- One sub-module, hazard_perf_cnt: 32-bit saturating counter with async active-low reset and inc input. Instantiated three times, only under HAZARD_PERF_CNT_EN.

Test Plan:
1. Load-use: MemRead_ex=1, RegWrite_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1, then defaults.
2. Non-hazards: rdAddr_ex=0 with rs1Addr_id=0, rs1Used_id=1; separately rdAddr_ex=7, rs1Addr_id=7, rs1Used_id=0 -> no stall in either case.
3. Multi-cycle, MC_LAT=4: MultiCycle_ex held high -> EXHold=1 for 3 cycles, mc_done=1 on the 4th, IDLE on the 5th. Two back-to-back ops -> 3+1+3+1 pattern.
4. Redirect with simultaneous load-use match -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, and no stall.
5. rst_n pulsed low in 2nd MC_BUSY cycle -> outputs return to reset values immediately; after release, state is IDLE and mc_done is never pulsed.
6. With HAZARD_PERF_CNT_EN: run scenarios 1, 3 and 4 once each -> ldu_stall_cnt=1, mc_stall_cnt=3, flush_cnt=1. Force counter to 32'hFFFF_FFFF, stall again -> counter stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/ex_hazard_pkg.sv
// Shared definitions for the EX-stage hazard controller: FSM encoding,
// default multi-cycle latency and the x0 register constant.
package ex_hazard_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam int MC_LAT_DEF = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: 32-bit event counter that sticks at all-ones instead of
// wrapping. Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing controller: load-use stalls, EX redirects and
// multi-cycle ALU holds. Optional perf counters under HAZARD_PERF_CNT_EN.
module ex_hazard_ctrl
    import ex_hazard_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DEF,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic [4:0]  rs1Addr_id,
    input  logic [4:0]  rs2Addr_id,
    input  logic        rs1Used_id,
    input  logic        rs2Used_id,
    input  logic        BranchTaken_ex,
    input  logic        MultiCycle_ex,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        EXHold,
    output logic        mc_busy,
    output logic        mc_done,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] ldu_stall_cnt,
    output logic [31:0] mc_stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output mc_state_t   dbg_state
);

    mc_state_t          state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic               ldu_hit;

    assign ldu_hit = MemRead_ex && RegWrite_ex && (rdAddr_ex != REG_ZERO) &&
                     ((rs1Used_id && (rdAddr_ex == rs1Addr_id)) ||
                      (rs2Used_id && (rdAddr_ex == rs2Addr_id)));

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXHold     = 1'b0;
        mc_busy    = 1'b0;
        mc_done    = 1'b0;
        case (state)
            IDLE: begin
                if (BranchTaken_ex) begin
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (MultiCycle_ex) begin
                    EXHold     = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    next_state = MC_BUSY;
                    next_cnt   = CNT_W'(MC_LAT - 2);
                end else if (ldu_hit) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            end
            MC_BUSY: begin
                // Pipeline inputs are frozen behind the held op, so ignore them here.
                mc_busy = 1'b1;
                if (cnt != '0) begin
                    EXHold    = 1'b1;
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    next_cnt  = cnt - CNT_W'(1);
                end else begin
                    mc_done    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    // IDEXFlush without IFIDFlush only happens on a load-use stall.
    hazard_perf_cnt u_ldu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (IDEXFlush && !IFIDFlush),
        .count (ldu_stall_cnt)
    );

    hazard_perf_cnt u_mc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (EXHold),
        .count (mc_stall_cnt)
    );

    hazard_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (IFIDFlush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl (MC_LAT=4); perf counter checks are
// compiled in only with HAZARD_PERF_CNT_EN.
module tb_ex_hazard_ctrl;
    import ex_hazard_pkg::*;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXHold, mc_busy, mc_done}
    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_LDU   = 7'b0001000;
    localparam logic [6:0] O_MCENT = 7'b0000100;
    localparam logic [6:0] O_MCBSY = 7'b0000110;
    localparam logic [6:0] O_MCDN  = 7'b1100011;
    localparam logic [6:0] O_REDIR = 7'b1111000;

    logic        clk;
    logic        rst_n;
    logic        MemRead_ex, RegWrite_ex;
    logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
    logic        rs1Used_id, rs2Used_id;
    logic        BranchTaken_ex, MultiCycle_ex;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXHold, mc_busy, mc_done;
    mc_state_t   dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ldu_stall_cnt, mc_stall_cnt, flush_cnt;
`endif
    logic [6:0]  outs;

    int total = 0;
    int bad   = 0;

    assign outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXHold, mc_busy, mc_done};

    ex_hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead_ex     (MemRead_ex),
        .RegWrite_ex    (RegWrite_ex),
        .rdAddr_ex      (rdAddr_ex),
        .rs1Addr_id     (rs1Addr_id),
        .rs2Addr_id     (rs2Addr_id),
        .rs1Used_id     (rs1Used_id),
        .rs2Used_id     (rs2Used_id),
        .BranchTaken_ex (BranchTaken_ex),
        .MultiCycle_ex  (MultiCycle_ex),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .IDEXFlush      (IDEXFlush),
        .EXHold         (EXHold),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done),
`ifdef HAZARD_PERF_CNT_EN
        .ldu_stall_cnt  (ldu_stall_cnt),
        .mc_stall_cnt   (mc_stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .dbg_state      (dbg_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        MemRead_ex = 0; RegWrite_ex = 0; rdAddr_ex = 0;
        rs1Addr_id = 0; rs2Addr_id = 0; rs1Used_id = 0; rs2Used_id = 0;
        BranchTaken_ex = 0; MultiCycle_ex = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2);
        MemRead_ex = 1; RegWrite_ex = 1; rdAddr_ex = rd;
        rs1Addr_id = rs1; rs2Addr_id = rs2; rs1Used_id = u1; rs2Used_id = u2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_DEF);
        end
        total++;
        if (dbg_state !== IDLE) begin
            bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive_load(5'd5, 5'd9, 5'd5, 1'b0, 1'b1);
        #1; total++;
        if (outs !== O_LDU) begin
            bad++; $display("FAIL ldu_rs2 got=%b exp=%b", outs, O_LDU);
        end
        @(negedge clk);
        clear_inputs();
        #1; total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL ldu_after got=%b exp=%b", outs, O_DEF);
        end
        @(negedge clk);
        drive_load(5'd12, 5'd12, 5'd3, 1'b1, 1'b1);
        #1; total++;
        if (outs !== O_LDU) begin
            bad++; $display("FAIL ldu_rs1 got=%b exp=%b", outs, O_LDU);
        end
        @(negedge clk);
        drive_load(5'd12, 5'd12, 5'd3, 1'b1, 1'b1);
        RegWrite_ex = 0;
        #1; total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL ldu_no_regwrite got=%b exp=%b", outs, O_DEF);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_non_hazard();
        @(negedge clk);
        drive_load(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        #1; total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL nohaz_x0 got=%b exp=%b", outs, O_DEF);
        end
        @(negedge clk);
        drive_load(5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
        #1; total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL nohaz_unused got=%b exp=%b", outs, O_DEF);
        end
        @(negedge clk);
        drive_load(5'd7, 5'd1, 5'd7, 1'b1, 1'b0);
        #1; total++;
        if (outs !== O_DEF) begin
            bad++; $display("FAIL nohaz_rs2_unused got=%b exp=%b", outs, O_DEF);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [6:0] pat [8];
        pat[0] = O_MCENT; pat[1] = O_MCBSY; pat[2] = O_MCBSY; pat[3] = O_MCDN;
        pat[4] = O_MCENT; pat[5] = O_MCBSY; pat[6] = O_MCBSY; pat[7] = O_MCDN;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            MultiCycle_ex = 1'b1;
            #1; total++;
            if (outs !== pat[i]) begin
                bad++; $display("FAIL mc_cycle%0d got=%b exp=%b", i, outs, pat[i]);
            end
        end
        @(negedge clk);
        MultiCycle_ex = 1'b0;
        #1; total++;
        if (outs !== O_DEF || dbg_state !== IDLE) begin
            bad++; $display("FAIL mc_idle got=%b/%0d exp=%b/0", outs, dbg_state, O_DEF);
        end
        // Inputs during MC_BUSY must not disturb the hold
        @(negedge clk);
        MultiCycle_ex = 1'b1;
        @(negedge clk);
        MultiCycle_ex = 1'b0;
        BranchTaken_ex = 1'b1;
        drive_load(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
        #1; total++;
        if (outs !== O_MCBSY) begin
            bad++; $display("FAIL mc_ignore got=%b exp=%b", outs, O_MCBSY);
        end
        clear_inputs();
        @(negedge clk);
        @(negedge clk); #1; total++;
        if (outs !== O_MCDN) begin
            bad++; $display("FAIL mc_done_single got=%b exp=%b", outs, O_MCDN);
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        BranchTaken_ex = 1'b1;
        drive_load(5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
        #1; total++;
        if (outs !== O_REDIR) begin
            bad++; $display("FAIL redir_ldu got=%b exp=%b", outs, O_REDIR);
        end
        @(negedge clk);
        clear_inputs();
        BranchTaken_ex = 1'b1;
        MultiCycle_ex  = 1'b1;
        #1; total++;
        if (outs !== O_REDIR) begin
            bad++; $display("FAIL redir_mc got=%b exp=%b", outs, O_REDIR);
        end
        @(negedge clk);
        clear_inputs();
        #1; total++;
        if (outs !== O_DEF || dbg_state !== IDLE) begin
            bad++; $display("FAIL redir_after got=%b/%0d exp=%b/0", outs, dbg_state, O_DEF);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        MultiCycle_ex = 1'b1;
        @(negedge clk);
        MultiCycle_ex = 1'b0;
        @(negedge clk); #1;
        total++;
        if (outs !== O_MCBSY) begin
            bad++; $display("FAIL rstmid_busy2 got=%b exp=%b", outs, O_MCBSY);
        end
        rst_n = 1'b0;
        #1; total++;
        if (outs !== O_DEF || dbg_state !== IDLE) begin
            bad++; $display("FAIL rstmid_async got=%b/%0d exp=%b/0", outs, dbg_state, O_DEF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++;
            if (outs !== O_DEF) begin
                bad++; $display("FAIL rstmid_after%0d got=%b exp=%b", i, outs, O_DEF);
            end
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        @(negedge clk);
        rst_n = 1'b0;
        #1; total++;
        if (ldu_stall_cnt !== 32'd0 || mc_stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            bad++; $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0",
                            ldu_stall_cnt, mc_stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_load(5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
        @(negedge clk);
        clear_inputs();
        MultiCycle_ex = 1'b1;
        @(negedge clk);
        MultiCycle_ex = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        BranchTaken_ex = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1; total++;
        if (ldu_stall_cnt !== 32'd1 || mc_stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            bad++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=1/3/1",
                            ldu_stall_cnt, mc_stall_cnt, flush_cnt);
        end
        force dut.u_ldu_cnt.count = 32'hFFFF_FFFF;
        #1;
        release dut.u_ldu_cnt.count;
        drive_load(5'd6, 5'd6, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        #1; total++;
        if (ldu_stall_cnt !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL perf_sat got=%h exp=ffffffff", ldu_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_non_hazard();
        test_back_to_back();
        test_redirect();
        test_reset_mid_op();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
